// File: rtl/rob_pkg.sv
// Shared definitions for the retire/complete arbiter.
//   IDX_W   - default ROB index width
//   EXC_W   - exception vector width
//   NUM_REQ - number of completion requesters (MEM, ALU, MUL)
//   req_e   - requester encoding, matching bit positions of the per-requester buses
//   cpl_entry_t - one queued completion {idx, value, exception} at default index width
//   rr_add  - modulo-NUM_REQ addition used by the round-robin search
package rob_pkg;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned EXC_W   = 3;
    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_MEM = 2'd0,
        REQ_ALU = 2'd1,
        REQ_MUL = 2'd2
    } req_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      value;
        logic [EXC_W-1:0] exc;
    } cpl_entry_t;

    // (ptr + off) mod NUM_REQ for ptr, off in 0..NUM_REQ-1
    function automatic logic [1:0] rr_add(input logic [1:0] ptr, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, ptr} + {1'b0, off};
        return (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
    endfunction

endpackage

// File: rtl/completion_fifo.sv
// Per-requester completion queue.
//   clk, reset  - clock and synchronous active-high reset
//   flush       - empties the queue (pointers and count to zero)
//   push, wdata - enqueue request; ignored while full
//   pop         - dequeue request; ignored while empty
//   rdata       - current head entry
//   full, empty - occupancy flags decoded from the registered count
module completion_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries counted as valid are ever read out
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/retire_complete_arbiter.sv
// Round-robin arbiter merging MEM/ALU/MUL completions into one ROB write port.
//   clk, reset            - clock and synchronous active-high reset
//   in_flush              - discards every pending completion
//   in_req_valid[2:0]     - per-requester valid (bit0 MEM, bit1 ALU, bit2 MUL)
//   in_req_idx/value/exception - per-requester payloads, requester r at slice r
//   out_req_ready[2:0]    - per-requester ready (queue not full)
//   out_complete          - registered ROB completion strobe
//   out_complete_idx/value, out_exception_vector - registered completion payload
//   out_grant[2:0]        - one-hot source of the current completion, zero when idle
module retire_complete_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDX_W = rob_pkg::IDX_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_flush,
    input  logic [rob_pkg::NUM_REQ-1:0]          in_req_valid,
    input  logic [rob_pkg::NUM_REQ*IDX_W-1:0]    in_req_idx,
    input  logic [rob_pkg::NUM_REQ*32-1:0]       in_req_value,
    input  logic [rob_pkg::NUM_REQ*rob_pkg::EXC_W-1:0] in_req_exception,
    output logic [rob_pkg::NUM_REQ-1:0]          out_req_ready,
    output logic                                 out_complete,
    output logic [IDX_W-1:0]                     out_complete_idx,
    output logic [31:0]                          out_complete_value,
    output logic [rob_pkg::EXC_W-1:0]            out_exception_vector,
    output logic [rob_pkg::NUM_REQ-1:0]          out_grant
);

    localparam int unsigned NR    = rob_pkg::NUM_REQ;
    localparam int unsigned EXC_W = rob_pkg::EXC_W;

    // Same layout as rob_pkg::cpl_entry_t, but sized by this instance's IDX_W
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      value;
        logic [EXC_W-1:0] exc;
    } entry_t;

    entry_t          wr_entry [NR];
    entry_t          head     [NR];
    logic [NR-1:0]   push;
    logic [NR-1:0]   pop;
    logic [NR-1:0]   full;
    logic [NR-1:0]   empty;
    logic [1:0]      rr_ptr;
    logic            gnt_any;
    logic [1:0]      gnt_sel;
    logic [1:0]      cand;

    for (genvar r = 0; r < NR; r++) begin : g_req
        assign wr_entry[r] = {in_req_idx[r*IDX_W +: IDX_W],
                              in_req_value[r*32 +: 32],
                              in_req_exception[r*EXC_W +: EXC_W]};
        assign push[r]     = in_req_valid[r] & ~full[r] & ~in_flush;

        completion_fifo #(
            .DEPTH (DEPTH),
            .WIDTH ($bits(entry_t))
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (in_flush),
            .push  (push[r]),
            .wdata (wr_entry[r]),
            .pop   (pop[r]),
            .rdata (head[r]),
            .full  (full[r]),
            .empty (empty[r])
        );
    end

    assign out_req_ready = ~full;

    // First non-empty queue in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); flush blocks the grant
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = rr_ptr;
        cand    = '0;
        for (int k = 0; k < NR; k++) begin
            cand = rob_pkg::rr_add(rr_ptr, 2'(k));
            if (!gnt_any && !empty[cand]) begin
                gnt_any = 1'b1;
                gnt_sel = cand;
            end
        end
        if (in_flush) gnt_any = 1'b0;
    end

    always_comb begin
        pop = '0;
        if (gnt_any) pop[gnt_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr               <= '0;
            out_complete         <= 1'b0;
            out_grant            <= '0;
            out_complete_idx     <= '0;
            out_complete_value   <= '0;
            out_exception_vector <= '0;
        end else begin
            out_complete <= gnt_any;
            out_grant    <= pop;
            if (gnt_any) begin
                out_complete_idx     <= head[gnt_sel].idx;
                out_complete_value   <= head[gnt_sel].value;
                out_exception_vector <= head[gnt_sel].exc;
                rr_ptr               <= rob_pkg::rr_add(gnt_sel, 2'd1);
            end
        end
    end

endmodule

// File: doc/retire_complete_arbiter.md
RETIRE_COMPLETE_ARBITER -- requirements
Module: retire_complete_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per requester queue (power of two, at least 2).
REQ-002 SHALL have parameter IDX_W, default 4, meaning ROB index width.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_flush  input  1  pipeline flush; discards all pending completions.
REQ-007 in_req_valid  input  3  per-requester valid (bit0 MEM, bit1 ALU, bit2 MUL).
REQ-008 in_req_idx  input  3*IDX_W  per-requester ROB index, packed with requester r at bits [r*IDX_W +: IDX_W].
REQ-009 in_req_value  input  3*32  per-requester result value, packed the same way.
REQ-010 in_req_exception  input  3*3  per-requester exception vector, packed the same way.
REQ-011 out_req_ready  output  3  per-requester ready, high while that queue is not full.
REQ-012 out_complete  output  1  ROB completion write strobe.
REQ-013 out_complete_idx  output  IDX_W  ROB index being completed.
REQ-014 out_complete_value  output  32  completion value.
REQ-015 out_exception_vector  output  3  exception vector of the completing entry.
REQ-016 out_grant  output  3  one-hot requester source of the current output; zero when idle.

Function
REQ-017 A request SHALL be accepted on a rising edge when valid and ready are both high and in_flush is low; otherwise it is dropped, and the requester must hold it.
REQ-018 Each requester SHALL own a FIFO of DEPTH entries {idx, value, exception} with a count from 0 to DEPTH; ready = (count != DEPTH), decoded combinationally from registered count.
REQ-019 Each cycle, the arbiter SHALL select at most one non-empty queue head, using round-robin from pointer rr_ptr (0..2).
REQ-020 Search order SHALL be rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
REQ-021 On a grant to requester g, rr_ptr SHALL become (g+1) mod 3; with no grant, rr_ptr holds.
REQ-022 The granted head SHALL pop and be registered onto the out_* ports at the same edge; outputs are fully registered.
REQ-023 Latency: a request accepted at edge E into empty queues, with no contention, SHALL appear on outputs during the cycle after edge E+1.
REQ-024 Throughput SHALL be one completion per cycle.
REQ-025 out_complete SHALL be high for exactly one cycle per accepted entry.
REQ-026 When no grant occurs, out_complete and out_grant SHALL be 0; idx, value and exception hold their previous values.
REQ-027 A queue SHALL handle push and pop in the same cycle (count unchanged); when count=DEPTH, a push is refused and a pop still proceeds.
REQ-028 Per-queue order SHALL be FIFO; read/write pointers wrap mod DEPTH.
REQ-029 in_flush SHALL clear all counts and pointers at the edge, drop same-cycle requests, and force out_complete=0 and out_grant=0 in the next cycle; rr_ptr is unchanged.
REQ-030 Flush SHALL take precedence over an arbitration in the same cycle.

Reset
REQ-031 On reset, all counts and FIFO pointers SHALL be 0, rr_ptr=0, out_complete=0, out_grant=0, out_complete_idx=0, out_complete_value=0 and out_exception_vector=0.
REQ-032 Reset SHALL take priority over flush and over requests; out_req_ready reads all-ones after reset.
REQ-033 Reset mid-operation SHALL discard all queued entries, and no pending entry is emitted afterward.

Structure
REQ-034 Package rob_pkg SHALL hold IDX_W, EXC_W=3, NUM_REQ=3, the requester enum (REQ_MEM=0, REQ_ALU=1, REQ_MUL=2) and the completion-entry struct.
REQ-035 A single sub-module, completion_fifo, instantiated three times, SHALL implement each queue (push, pop, count, head); arbitration and output registers stay in the top module.

Verification
REQ-036 Single request: after reset, ALU valid for one cycle with idx=5, value=0xDEADBEEF, exception=0 -> two cycles later, out_complete=1, idx=5, value=0xDEADBEEF, out_grant=3'b010 for one cycle.
REQ-037 Contention: all three requesters valid in the same cycle (idx 1/2/3) -> completions on three consecutive cycles in order MEM, ALU, MUL; rr_ptr ends at 0.
REQ-038 Full queue: MEM pushes 3 entries back-to-back with the output path blocked by continuous ALU/MUL traffic -> out_req_ready[0]=0 after 2 entries; the third is held and accepted once the queue pops; entries emerge in order.
REQ-039 Flush: 2 entries queued in each queue, then in_flush for one cycle -> next cycle out_complete=0; no old index ever appears; a new request after flush completes normally.
REQ-040 Reset mid-stream: reset asserted while 4 entries are pending -> all outputs are 0 next cycle, ready=3'b111, and no pending entry is emitted afterward.
REQ-041 Exception passthrough: MUL idx=9, exception=3'b100 -> out_exception_vector=3'b100 with idx 9 and out_grant=3'b100.
